// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR write unit: operation
// encoding, CSR address map and mcountinhibit bit positions.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Writable machine-mode counters (B range) and their read-only
    // user-mode shadows (C range).
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // mcountinhibit bit positions; only these bits are implemented.
    localparam int CNT_INH_CY = 0;
    localparam int CNT_INH_IR = 2;
    localparam logic [31:0] MCOUNTINHIBIT_MASK =
        (32'd1 << CNT_INH_CY) | (32'd1 << CNT_INH_IR);

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independent 32-bit half loads. A load of either half
// takes priority over incrementing, and the untouched half keeps its value.
import csr_pkg::*;

module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Next count: half loads suppress the increment for the whole counter.
    always_comb begin
        count_d = count_q;
        if (lo_we || hi_we) begin
            if (lo_we) count_d[31:0]  = wdata;
            if (hi_we) count_d[63:32] = wdata;
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/csr_rw_unit.sv
// WB-stage CSR unit owning mcycle, minstret and mscratch. Returns the old CSR
// value combinationally and performs CSRRW/CSRRS/CSRRC writes on the edge.
// Defining CSR_INHIBIT_EN adds mcountinhibit (0x320, CY and IR bits).
import csr_pkg::*;

module csr_rw_unit #(
    parameter int          CYCLE_RD_OFFSET = 4,
    parameter logic [31:0] MSCRATCH_RST    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic        valid_inst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        rs1_zero,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal
);

    csr_op_e     op;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] mscratch_q;
    logic [31:0] mscratch_d;
    logic        addr_known;
    logic        addr_is_c;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        stalled;
    logic        write_req;
    logic        we;
    logic        inh_cy;
    logic        inh_ir;
    logic [31:0] mcountinhibit_val;

    assign op      = csr_op_e'(csr_op);
    assign stalled = IM_stall | DM_stall;

`ifdef CSR_INHIBIT_EN
    logic [31:0] mcountinhibit_q;
    logic [31:0] mcountinhibit_d;

    // Only the CY and IR bits are stored; others always read as zero.
    always_comb begin
        mcountinhibit_d = mcountinhibit_q;
        if (we && csr_addr == CSR_MCOUNTINHIBIT)
            mcountinhibit_d = new_val & MCOUNTINHIBIT_MASK;
    end

    // mcountinhibit register; a write affects increments from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) mcountinhibit_q <= '0;
        else     mcountinhibit_q <= mcountinhibit_d;
    end

    assign mcountinhibit_val = mcountinhibit_q;
`else
    assign mcountinhibit_val = '0;
`endif

    assign inh_cy = mcountinhibit_val[CNT_INH_CY];
    assign inh_ir = mcountinhibit_val[CNT_INH_IR];

    // Address decode: select the raw (pre-update) value of the addressed CSR.
    always_comb begin
        addr_known = 1'b1;
        old_val    = '0;
        case (csr_addr)
            CSR_MCYCLE,   CSR_CYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
            CSR_MSCRATCH:               old_val = mscratch_q;
`ifdef CSR_INHIBIT_EN
            CSR_MCOUNTINHIBIT:          old_val = mcountinhibit_val;
`endif
            default:                    addr_known = 1'b0;
        endcase
    end

    assign addr_is_c = (csr_addr[11:8] == 4'hC);

    // A write is attempted only for real set/clear/swap ops outside stalls;
    // RS/RC with a zero source are pure reads.
    assign write_req = csr_en && !stalled && (op != CSR_OP_NONE) &&
                       ((op == CSR_OP_RW) || !rs1_zero);

    assign csr_illegal = csr_en && (!addr_known || (addr_is_c && write_req));
    assign we          = write_req && !csr_illegal;

    // Cycle reads are compensated for WB latency; writes use the raw value.
    assign csr_rdata = (csr_addr == CSR_MCYCLE || csr_addr == CSR_CYCLE) ?
                       (old_val - 32'(CYCLE_RD_OFFSET)) : old_val;

    // Value to be written, derived from the raw old value.
    always_comb begin
        new_val = csr_wdata;
        case (op)
            CSR_OP_RS: new_val = old_val | csr_wdata;
            CSR_OP_RC: new_val = old_val & ~csr_wdata;
            default:   new_val = csr_wdata;
        endcase
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (!inh_cy),
        .lo_we  (we && csr_addr == CSR_MCYCLE),
        .hi_we  (we && csr_addr == CSR_MCYCLEH),
        .wdata  (new_val),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (valid_inst && !stalled && !inh_ir),
        .lo_we  (we && csr_addr == CSR_MINSTRET),
        .hi_we  (we && csr_addr == CSR_MINSTRETH),
        .wdata  (new_val),
        .count  (minstret)
    );

    // mscratch next value: loaded only on a committed write to 0x340.
    always_comb begin
        mscratch_d = mscratch_q;
        if (we && csr_addr == CSR_MSCRATCH) mscratch_d = new_val;
    end

    // mscratch register with parameterised reset value.
    always_ff @(posedge clk) begin
        if (rst) mscratch_q <= MSCRATCH_RST;
        else     mscratch_q <= mscratch_d;
    end

endmodule
